// File: rtl/kd_pkg.sv
// rtl/kd_pkg.sv - shared constants and types for the INTT halving stage
//
// Moduli, polynomial lengths, lane widths and the Kyber/Dilithium mode
// encoding used by kd_intt_half_pipe and its lane sub-module.
package kd_pkg;

    localparam int unsigned KQ      = 3329;
    localparam int unsigned DQ      = 8380417;
    localparam int unsigned K_WORDS = 128;
    localparam int unsigned D_WORDS = 256;

    localparam int KW    = 12;
    localparam int DW    = 24;
    localparam int CNT_W = 8;

    typedef enum logic {
        KD_MODE_K = 1'b0,
        KD_MODE_D = 1'b1
    } kd_mode_e;

endpackage

// File: rtl/mod_half_lane.sv
// rtl/mod_half_lane.sv - combinational x * 2^-1 mod Q for one lane
//
// Ports:
//   x_i : lane value, expected in [0,Q)
//   r_o : x/2 when x is even, (x+Q)/2 when x is odd
// Q is odd, so x+Q is even whenever x is odd and the shift is exact. The
// sum needs one extra bit; for x in [0,Q) the result stays in [0,Q).
module mod_half_lane #(
    parameter int          W = 12,
    parameter int unsigned Q = 3329
) (
    input  logic [W-1:0] x_i,
    output logic [W-1:0] r_o
);

    logic [W:0] sum;

    assign sum = {1'b0, x_i} + (W+1)'(Q);
    assign r_o = x_i[0] ? sum[W:1] : {1'b0, x_i[W-1:1]};

endmodule

// File: rtl/kd_intt_half_pipe.sv
// rtl/kd_intt_half_pipe.sv - two-stage pipelined modular halving for the INTT path
//
// Ports:
//   clk, rst          : clock, asynchronous active-high reset
//   KD_mode           : 0=Kyber dual 12-bit lanes, 1=Dilithium 24-bit lane;
//                       sampled on the first word of each polynomial
//   halve_en          : per word, 1=halve, 0=pass through
//   in_valid/in_ready/in_data    : input stream
//   out_valid/out_ready/out_data : output stream, same packing as input
//   out_last          : marks the final word of a polynomial
//   busy              : polynomial in progress or pipeline occupied
// Optional (macro KD_HALF_RANGE_CHECK_EN):
//   range_err         : sticky, set when an accepted lane is >= q
//   clr_err           : synchronous clear of range_err (set wins)
module kd_intt_half_pipe
    import kd_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        KD_mode,
    input  logic        halve_en,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [23:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [23:0] out_data,
    output logic        out_last,
    output logic        busy
`ifdef KD_HALF_RANGE_CHECK_EN
    ,
    output logic        range_err,
    input  logic        clr_err
`endif
);

    // Word counter and the mode latched for the polynomial in progress.
    logic [CNT_W-1:0] cnt_q, cnt_d;
    kd_mode_e         mode_q;

    // Stage 1: captured input word and its tags.
    logic             s1_valid_q;
    logic [23:0]      s1_data_q;
    logic             s1_halve_q;
    kd_mode_e         s1_mode_q;
    logic             s1_last_q;

    // Stage 2: computed result feeding the output port directly.
    logic             s2_valid_q;
    logic [23:0]      s2_data_q;
    logic             s2_last_q;

    logic             adv2, adv1, accept, first_word, term;
    kd_mode_e         eff_mode;

    logic [KW-1:0]    k_lo_r, k_hi_r;
    logic [DW-1:0]    d_r;
    logic [23:0]      half_w, res_w;

    // A stage may load when it is empty or its content leaves this cycle.
    assign adv2     = !s2_valid_q || out_ready;
    assign adv1     = !s1_valid_q || adv2;
    assign in_ready = adv1;
    assign accept   = in_valid && adv1;

    // The first word of a polynomial uses the live mode pin; every later
    // word uses the latched copy so mid-polynomial toggles are ignored.
    assign first_word = (cnt_q == '0);
    assign eff_mode   = first_word ? kd_mode_e'(KD_mode) : mode_q;
    assign term       = (eff_mode == KD_MODE_D) ? (cnt_q == CNT_W'(D_WORDS - 1))
                                                : (cnt_q == CNT_W'(K_WORDS - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (accept) begin
            cnt_d = term ? '0 : cnt_q + CNT_W'(1);
        end
    end

    mod_half_lane #(.W(KW), .Q(KQ)) u_lane_lo (
        .x_i (s1_data_q[11:0]),
        .r_o (k_lo_r)
    );

    mod_half_lane #(.W(KW), .Q(KQ)) u_lane_hi (
        .x_i (s1_data_q[23:12]),
        .r_o (k_hi_r)
    );

    mod_half_lane #(.W(DW), .Q(DQ)) u_lane_d (
        .x_i (s1_data_q),
        .r_o (d_r)
    );

    assign half_w = (s1_mode_q == KD_MODE_D) ? d_r : {k_hi_r, k_lo_r};
    assign res_w  = s1_halve_q ? half_w : s1_data_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q      <= '0;
            mode_q     <= KD_MODE_K;
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
            s1_halve_q <= 1'b0;
            s1_mode_q  <= KD_MODE_K;
            s1_last_q  <= 1'b0;
            s2_valid_q <= 1'b0;
            s2_data_q  <= '0;
            s2_last_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            if (accept && first_word) begin
                mode_q <= eff_mode;
            end

            if (adv1) begin
                s1_valid_q <= in_valid;
                if (in_valid) begin
                    s1_data_q  <= in_data;
                    s1_halve_q <= halve_en;
                    s1_mode_q  <= eff_mode;
                    s1_last_q  <= term;
                end
            end

            if (adv2) begin
                s2_valid_q <= s1_valid_q;
                // Drop the last tag with an empty slot so out_last never
                // lingers after the final word has left.
                s2_last_q  <= s1_valid_q && s1_last_q;
                if (s1_valid_q) begin
                    s2_data_q <= res_w;
                end
            end
        end
    end

    assign out_valid = s2_valid_q;
    assign out_data  = s2_data_q;
    assign out_last  = s2_last_q;
    assign busy      = (cnt_q != '0) || s1_valid_q || s2_valid_q;

`ifdef KD_HALF_RANGE_CHECK_EN
    logic range_err_q;
    logic oor;

    // Checked at acceptance against the word's own mode.
    assign oor = (eff_mode == KD_MODE_D) ? (in_data >= 24'(DQ))
                                         : ((in_data[11:0]  >= 12'(KQ)) ||
                                            (in_data[23:12] >= 12'(KQ)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            range_err_q <= 1'b0;
        end else if (accept && oor) begin
            range_err_q <= 1'b1;
        end else if (clr_err) begin
            range_err_q <= 1'b0;
        end
    end

    assign range_err = range_err_q;
`endif

endmodule

// File: tb/tb_kd_intt_half_pipe.sv
// tb/tb_kd_intt_half_pipe.sv - directed self-checking bench for kd_intt_half_pipe
module tb_kd_intt_half_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        KD_mode;
    logic        halve_en;
    logic        in_valid;
    logic        in_ready;
    logic [23:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [23:0] out_data;
    logic        out_last;
    logic        busy;
`ifdef KD_HALF_RANGE_CHECK_EN
    logic        range_err;
    logic        clr_err;
`endif

    int vectors = 0;
    int errors  = 0;
    int stall_pct = 0;
    int cyc = 0;

    logic [23:0] rx_data[$];
    logic        rx_last[$];
    int          rx_cyc[$];

    always #5 clk = ~clk;

    kd_intt_half_pipe dut (
        .clk       (clk),
        .rst       (rst),
        .KD_mode   (KD_mode),
        .halve_en  (halve_en),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy)
`ifdef KD_HALF_RANGE_CHECK_EN
        ,
        .range_err (range_err),
        .clr_err   (clr_err)
`endif
    );

    always @(posedge clk) cyc <= cyc + 1;

    // Output transfers are recorded at the negedge preceding their edge.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            rx_data.push_back(out_data);
            rx_last.push_back(out_last);
            rx_cyc.push_back(cyc);
        end
    end

    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            out_ready = (stall_pct == 0) ? 1'b1 : ($urandom_range(99) >= stall_pct);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int half_ref(int x, int q, bit h);
        if (!h) return x;
        return (x % 2 == 1) ? (x + q) / 2 : x / 2;
    endfunction

    function automatic logic [23:0] k_exp(logic [23:0] d, bit h);
        int lo, hi;
        lo = half_ref(int'(d[11:0]), 3329, h);
        hi = half_ref(int'(d[23:12]), 3329, h);
        return {12'(hi), 12'(lo)};
    endfunction

    function automatic logic [23:0] d_exp(logic [23:0] d, bit h);
        return 24'(half_ref(int'(d), 8380417, h));
    endfunction

    task automatic clear_rx;
        rx_data.delete();
        rx_last.delete();
        rx_cyc.delete();
    endtask

    task automatic do_reset;
        rst = 1'b1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        clear_rx();
    endtask

    // Present one word and hold it until accepted; returns at posedge+1.
    task automatic send(input logic [23:0] d, input logic m, input logic h);
        int n = 0;
        in_data  = d;
        KD_mode  = m;
        halve_en = h;
        in_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            n++;
            if (n > 300) begin
                vectors++;
                errors++;
                $display("FAIL send_timeout: in_ready=%0b after %0d cycles, required 1", in_ready, n);
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_rx(input int n);
        int c = 0;
        while (rx_data.size() < n && c < 3000) begin
            @(negedge clk);
            c++;
        end
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        in_valid = 1'b0;
        KD_mode = 1'b0;
        halve_en = 1'b0;
        in_data = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        vectors++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b, required 0", out_valid); end
        vectors++; if (out_data !== 24'd0) begin errors++; $display("FAIL reset_out_data: got %0d, required 0", out_data); end
        vectors++; if (out_last !== 1'b0) begin errors++; $display("FAIL reset_out_last: got %b, required 0", out_last); end
        vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b, required 0", busy); end
        vectors++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b, required 1", in_ready); end
        @(posedge clk);
        #1;
        clear_rx();
    endtask

    task automatic test_kyber_single;
        do_reset();
        send({12'd1, 12'd3328}, 1'b0, 1'b1);
        @(negedge clk);
        vectors++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ksingle_lat1: out_valid=%b, required 0", out_valid); end
        @(negedge clk);
        vectors++; if (out_valid !== 1'b1) begin errors++; $display("FAIL ksingle_lat2: out_valid=%b, required 1", out_valid); end
        vectors++; if (out_data !== {12'd1665, 12'd1664}) begin errors++; $display("FAIL ksingle_data: got %h, required %h", out_data, {12'd1665, 12'd1664}); end
        vectors++; if (out_last !== 1'b0) begin errors++; $display("FAIL ksingle_last: got %b, required 0", out_last); end
        @(negedge clk);
        vectors++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ksingle_one_cycle: out_valid=%b, required 0", out_valid); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_dilithium_stream;
        time t0;
        logic [23:0] exp_v[3];
        exp_v[0] = 24'd4190209;
        exp_v[1] = 24'd4190208;
        exp_v[2] = 24'd8380416;
        do_reset();
        t0 = $time;
        send(24'd1, 1'b1, 1'b1);
        send(24'd8380416, 1'b1, 1'b1);
        send(24'd8380415, 1'b1, 1'b1);
        vectors++; if (($time - t0) != 30) begin errors++; $display("FAIL dil_in_rate: took %0t, required 30", $time - t0); end
        wait_rx(3);
        vectors++;
        if (rx_data.size() != 3) begin
            errors++; $display("FAIL dil_count: got %0d words, required 3", rx_data.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                vectors++; if (rx_data[i] !== exp_v[i]) begin errors++; $display("FAIL dil_word%0d: got %0d, required %0d", i, rx_data[i], exp_v[i]); end
            end
            vectors++; if (rx_cyc[2] - rx_cyc[0] != 2) begin errors++; $display("FAIL dil_out_rate: span %0d cycles, required 2", rx_cyc[2] - rx_cyc[0]); end
        end
    endtask

    task automatic test_passthrough;
        do_reset();
        send({12'd3327, 12'd2}, 1'b0, 1'b0);
        send({12'd3327, 12'd2}, 1'b0, 1'b1);
        wait_rx(2);
        vectors++;
        if (rx_data.size() != 2) begin
            errors++; $display("FAIL pass_count: got %0d words, required 2", rx_data.size());
        end else begin
            vectors++; if (rx_data[0] !== {12'd3327, 12'd2}) begin errors++; $display("FAIL pass_bypass: got %h, required %h", rx_data[0], {12'd3327, 12'd2}); end
            vectors++; if (rx_data[1] !== {12'd3328, 12'd1}) begin errors++; $display("FAIL pass_halved: got %h, required %h", rx_data[1], {12'd3328, 12'd1}); end
        end
    endtask

    task automatic test_poly_boundary;
        logic [23:0] exp_d[$];
        logic        exp_l[$];
        logic [23:0] d;
        do_reset();
        for (int i = 0; i < 128; i++) begin
            d = {12'((i * 29 + 7) % 3329), 12'((i * 13) % 3329)};
            exp_d.push_back(k_exp(d, 1'b1));
            exp_l.push_back(i == 127);
            send(d, (i == 0) ? 1'b0 : 1'(i % 2), 1'b1);
        end
        for (int j = 0; j < 256; j++) begin
            d = 24'((j * 32771 + 5) % 8380417);
            exp_d.push_back(d_exp(d, 1'b1));
            exp_l.push_back(j == 255);
            send(d, (j == 0) ? 1'b1 : 1'((j + 1) % 2), 1'b1);
        end
        wait_rx(384);
        vectors++;
        if (rx_data.size() != 384) begin
            errors++; $display("FAIL poly_count: got %0d words, required 384", rx_data.size());
        end else begin
            for (int k = 0; k < 384; k++) begin
                vectors++; if (rx_data[k] !== exp_d[k]) begin errors++; $display("FAIL poly_data%0d: got %h, required %h", k, rx_data[k], exp_d[k]); end
                vectors++; if (rx_last[k] !== exp_l[k]) begin errors++; $display("FAIL poly_last%0d: got %b, required %b", k, rx_last[k], exp_l[k]); end
            end
        end
        vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL poly_busy_end: got %b, required 0", busy); end
    endtask

    task automatic test_stall;
        localparam int N = 64;
        logic [23:0] words[N];
        logic        hv[N];
        logic [23:0] exp_d[N];
        do_reset();
        for (int i = 0; i < N; i++) begin
            words[i] = {12'($urandom_range(3328)), 12'($urandom_range(3328))};
            hv[i]    = 1'($urandom_range(1));
            exp_d[i] = k_exp(words[i], hv[i]);
        end
        stall_pct = 30;
        fork
            begin
                for (int i = 0; i < N; i++) send(words[i], 1'b0, hv[i]);
            end
            begin
                int occ = 0;
                logic pv = 1'b0;
                logic [23:0] pd = '0;
                logic pl = 1'b0;
                for (int c = 0; c < 2000 && rx_data.size() < N; c++) begin
                    @(negedge clk);
                    if (pv) begin
                        vectors++;
                        if (out_valid !== 1'b1 || out_data !== pd || out_last !== pl) begin
                            errors++;
                            $display("FAIL stall_hold: got v=%b d=%h l=%b, required v=1 d=%h l=%b", out_valid, out_data, out_last, pd, pl);
                        end
                    end
                    vectors++;
                    if (in_ready !== !(occ == 2 && !out_ready)) begin
                        errors++;
                        $display("FAIL stall_in_ready: got %b, required %b (occupancy %0d)", in_ready, !(occ == 2 && !out_ready), occ);
                    end
                    occ = occ + int'(in_valid && in_ready) - int'(out_valid && out_ready);
                    pv = out_valid && !out_ready;
                    pd = out_data;
                    pl = out_last;
                end
            end
        join
        stall_pct = 0;
        wait_rx(N);
        vectors++;
        if (rx_data.size() != N) begin
            errors++; $display("FAIL stall_count: got %0d words, required %0d", rx_data.size(), N);
        end else begin
            for (int i = 0; i < N; i++) begin
                vectors++; if (rx_data[i] !== exp_d[i]) begin errors++; $display("FAIL stall_data%0d: got %h, required %h", i, rx_data[i], exp_d[i]); end
            end
        end
    endtask

    task automatic test_reset_mid;
        int nlast;
        do_reset();
        for (int i = 0; i < 50; i++) send({12'(i), 12'(i + 1)}, 1'b0, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        stall_pct = 100;
        @(posedge clk);
        #1;
        send({12'd50, 12'd51}, 1'b0, 1'b1);
        send({12'd51, 12'd52}, 1'b0, 1'b1);
        vectors++; if (in_ready !== 1'b0) begin errors++; $display("FAIL mid_full_in_ready: got %b, required 0", in_ready); end
        #2;
        rst = 1'b1;
        #1;
        vectors++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_out_valid: got %b, required 0", out_valid); end
        vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy: got %b, required 0", busy); end
        vectors++; if (out_last !== 1'b0) begin errors++; $display("FAIL mid_out_last: got %b, required 0", out_last); end
        stall_pct = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        clear_rx();
        for (int i = 0; i < 128; i++) send({12'(i * 3), 12'(i * 7)}, 1'b0, 1'b1);
        wait_rx(128);
        vectors++;
        if (rx_data.size() != 128) begin
            errors++; $display("FAIL mid_count: got %0d words, required 128", rx_data.size());
        end else begin
            nlast = 0;
            foreach (rx_last[k]) if (rx_last[k] === 1'b1) nlast++;
            vectors++; if (nlast != 1) begin errors++; $display("FAIL mid_last_count: got %0d, required 1", nlast); end
            vectors++; if (rx_last[127] !== 1'b1) begin errors++; $display("FAIL mid_last_pos: word 127 last=%b, required 1", rx_last[127]); end
        end
    endtask

`ifdef KD_HALF_RANGE_CHECK_EN
    task automatic test_range_check;
        do_reset();
        vectors++; if (range_err !== 1'b0) begin errors++; $display("FAIL range_reset: got %b, required 0", range_err); end
        send({12'd0, 12'd3329}, 1'b0, 1'b1);
        vectors++; if (range_err !== 1'b1) begin errors++; $display("FAIL range_set: got %b, required 1", range_err); end
        repeat (3) @(posedge clk);
        #1;
        vectors++; if (range_err !== 1'b1) begin errors++; $display("FAIL range_sticky: got %b, required 1", range_err); end
        clr_err = 1'b1;
        @(posedge clk);
        #1;
        clr_err = 1'b0;
        vectors++; if (range_err !== 1'b0) begin errors++; $display("FAIL range_clear: got %b, required 0", range_err); end
        wait_rx(1);
    endtask
`endif

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        KD_mode = 1'b0;
        halve_en = 1'b0;
        in_data = '0;
`ifdef KD_HALF_RANGE_CHECK_EN
        clr_err = 1'b0;
`endif
        test_reset();
        test_kyber_single();
        test_dilithium_stream();
        test_passthrough();
        test_poly_boundary();
        test_stall();
        test_reset_mid();
`ifdef KD_HALF_RANGE_CHECK_EN
        test_range_check();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/kd_intt_half_pipe.md
Name: kd_intt_half_pipe

Overview:
- Pipelined modular halving stage, x·2⁻¹ mod q, placed after the shared butterfly adder on the INTT path.
- Consumes butterfly sums and differences and returns halved coefficients, so that INTT scaling is folded into each layer.
- Kyber mode: two 12-bit lanes per 24-bit word, q=3329. Dilithium mode: one 24-bit lane, q=8380417.
- Uses a valid/ready stream with a per-polynomial word counter and end-of-polynomial flag.

Parameters:
KQ, 3329, Kyber modulus
DQ, 8380417, Dilithium modulus
K_WORDS, 128, words per Kyber polynomial (2 coefficients per word)
D_WORDS, 256, words per Dilithium polynomial

Ports:
clk  input  1  system clock
rst  input  1  asynchronous active-high reset
KD_mode  input  1  0=Kyber dual-lane, 1=Dilithium 24-bit; sampled only on the first word of a polynomial
halve_en  input  1  per-word: 1=halve, 0=pass through unchanged
in_valid  input  1  input word valid
in_ready  output  1  block can accept a word
in_data  input  24  Kyber {hi[23:12],lo[11:0]} or Dilithium coefficient
out_valid  output  1  output word valid
out_ready  input  1  downstream accepts
out_data  output  24  halved word, same packing as the input
out_last  output  1  high with the last word of the polynomial
busy  output  1  a polynomial is in progress (word count non-zero or pipeline occupied)

Behaviour:
- Reset (async, rst=1):
  - all stage valids=0, counter=0, latched mode=0.
  - out_valid=0, out_data=0, out_last=0, busy=0, in_ready=1 on the cycle after reset is released.
- Handshake:
  - A transfer occurs when valid&&ready on the same edge.
  - out_data and out_last are held stable while out_valid=1 and out_ready=0.
- Two register stages, S1 and S2; latency is 2 cycles from input acceptance to out_valid with no stall.
- Advance rules:
  - S2 advances when !s2_valid || out_ready.
  - S1 advances when !s1_valid || S2 advances.
  - in_ready = S1 advances (combinational from out_ready).
  - Full throughput is one word per cycle.
- S1 captures in_data, halve_en, the parity bit of each lane, and the effective mode.
- S2 computes the result. Per lane, with x in [0,q):
  - halve: r = x[0] ? (x+q)>>1 : x>>1.
  - Kyber lanes use 13-bit sums; Dilithium uses a 25-bit sum.
  - r is always in [0,q), so no final reduction is needed.
  - With halve_en=0: r=x.
  - Kyber computes both lanes independently.
- Mode latch:
  - On acceptance of a word when counter==0, KD_mode is latched and used for the whole polynomial.
  - KD_mode changes mid-polynomial are ignored.
- Counter:
  - Increments on each accepted input word.
  - Terminal count is K_WORDS-1 (Kyber) or D_WORDS-1 (Dilithium). On acceptance of the terminal word the counter wraps to 0 and the last tag travels with that word to out_last.
- Back-to-back polynomials: the next polynomial's first word may be accepted on the cycle after the terminal word, with a new mode sampled. Each word carries its mode through the pipe.
- Out-of-range input (x ≥ q) is undefined arithmetically, but the output still has the lane width (truncated) and no hang occurs.
- Reset mid-polynomial: all in-flight words are dropped, the counter returns to 0, and no out_last is emitted.

Optional Feature:
- Macro: KD_HALF_RANGE_CHECK_EN.
- When defined:
  - Adds output range_err (1 bit) and input clr_err (1 bit).
  - range_err is a sticky flag set when an accepted lane has x ≥ q (using the word's mode), visible the cycle after acceptance.
  - clr_err clears the flag synchronously; reset clears it to 0.
  - A set and a clear in the same cycle resolve as set.
- When undefined: these ports are absent and there is no compare logic.

Decomposition:
- Shared package kd_pkg holds KQ, DQ, K_WORDS, D_WORDS, the mode encoding (KD_MODE_K=0, KD_MODE_D=1) and the lane widths (12/24).
- One sub-module, mod_half_lane:
  - parameterised width W and modulus Q.
  - combinational r = x[0] ? (x+Q)>>1 : x>>1.
  - instantiated twice at W=12 and once at W=24, with the output muxed by the word's mode.

Test Plan:
- Kyber single word, halve_en=1, in_data={12'd1,12'd3328}, out_ready=1 → two cycles later out_data={12'd1665,12'd1664}, out_valid for 1 cycle.
- Dilithium, in_data=1, then 8380416, then 8380415 → out 4190209, 4190208, 8380416 in order, at 1 word/cycle.
- halve_en=0, Kyber {3327,2} → {3327,2} unchanged; same with halve_en=1 → {3328,1}.
- Full Kyber polynomial of 128 words with KD_mode toggled mid-stream → mode stays Kyber, out_last only on word 127. Then an immediate Dilithium polynomial → out_last on word 255.
- Random out_ready stalls with a 30% drop rate → no loss, duplication or reorder; out_data stable during stall; in_ready low only while both stages are full and out_ready=0.
- Assert rst at word 50 with the pipe full → out_valid=0 and busy=0 immediately, counter=0; the next polynomial's out_last lands on its own word 127.
- With KD_HALF_RANGE_CHECK_EN: Kyber lane 3329 → range_err=1 and sticky; clr_err → 0.
